// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, mid-bit sampling,
// configurable data width / parity / stop bits, false-start rejection,
// break handling and a held valid/acknowledge output with error flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a low level on the synchronised line
// S_START | timing half a bit into the start bit to confirm it is real
// S_DATA  | sampling payload bits LSB first, one per bit period
// S_PAR   | sampling the parity bit
// S_STOP  | sampling stop bit(s); the last one completes the frame
// S_BREAK | last stop bit was low; wait for the line to return high
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clc,
  input  logic                 res,
  input  logic                 RX,
  input  logic                 ENABLE,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] word_receiver,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_ferr;
  logic [DATA_BITS-1:0]   r_word;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_frerr;
  logic                   r_ovr;

  logic w_rx_s;
  logic w_tick;
  logic w_half;
  logic w_complete;
  logic w_par_calc;
  logic w_perr_new;
  logic w_ferr_new;

  assign w_rx_s     = r_sync2;
  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_half     = (r_cnt == CNT_HALF);
  assign w_par_calc = (^r_shift) ^ r_par_bit;
  assign w_perr_new = (PARITY == 1) ? ~w_par_calc :
                      (PARITY == 2) ?  w_par_calc : 1'b0;
  // The current stop sample is folded in so a low final stop bit is reported.
  assign w_ferr_new = r_ferr | ~w_rx_s;

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state decode; ENABLE low forces IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    if (!ENABLE) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!w_rx_s) w_state_nxt = S_START;
        S_START: if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (w_tick && (r_idx == IDX_LAST))
                   w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
        S_PAR:   if (w_tick) w_state_nxt = S_STOP;
        S_STOP:  if (w_tick && (r_stop_idx == STOP_LAST)) begin
                   w_complete  = 1'b1;
                   w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
                 end
        S_BREAK: if (w_rx_s) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register and bit-period counter; the counter restarts on every
  // state change and wraps at the end of each bit period.
  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) ||
          (r_state == S_BREAK) || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame datapath: payload shift register, parity bit, stop bookkeeping.
  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_idx      <= '0;
        r_ferr     <= 1'b0;
        r_stop_idx <= 1'b0;
      end
      if ((r_state == S_DATA) && w_tick) begin
        r_idx   <= r_idx + 1'b1;
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
      if ((r_state == S_PAR) && w_tick)
        r_par_bit <= w_rx_s;
      if ((r_state == S_STOP) && w_tick) begin
        r_ferr     <= w_ferr_new;
        r_stop_idx <= ~r_stop_idx;
      end
    end
  end

  // Output holding register: load on completion unless a previous frame is
  // still unacknowledged, in which case the new frame is dropped.
  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_frerr <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_complete) begin
      if (!r_valid || rx_ack) begin
        r_word  <= r_shift;
        r_perr  <= w_perr_new;
        r_frerr <= w_ferr_new;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (rx_ack && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign word_receiver = r_word;
  assign rx_valid      = r_valid;
  assign parity_err    = r_perr;
  assign frame_err     = r_frerr;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (16/8/even/1 and 4/9/odd/2)
// driven from a table of frames plus hand-written corner-case sequences.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0] w_a;
  logic [8:0] w_b;
  logic       v_a, pe_a, fe_a, ov_a;
  logic       v_b, pe_b, fe_b, ov_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_a = 0, start_b = 0;
  int rise_a = -1, rise_b = -1;
  logic pv_a = 1'b0, pv_b = 1'b0;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .clc(clk), .res(res), .RX(rx_a), .ENABLE(en), .rx_ack(ack_a),
    .word_receiver(w_a), .rx_valid(v_a), .parity_err(pe_a),
    .frame_err(fe_a), .overrun(ov_a));

  uart_rx_param #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clc(clk), .res(res), .RX(rx_b), .ENABLE(en), .rx_ack(ack_b),
    .word_receiver(w_b), .rx_valid(v_b), .parity_err(pe_b),
    .frame_err(fe_b), .overrun(ov_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // rx_valid rising-edge monitor: records the edge number that raised it
  always @(negedge clk) begin
    if (v_a && !pv_a) rise_a = cyc;
    if (v_b && !pv_b) rise_b = cyc;
    pv_a = v_a;
    pv_b = v_b;
  end

  typedef struct {
    bit         dut;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    bit         ack;
    bit         lat;
    logic [8:0] e_word;
    logic       e_valid;
    logic       e_perr;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit d, input logic v);
    if (d) rx_b = v; else rx_a = v;
  endtask

  task automatic chk_out(input bit d, input string nm, input logic [8:0] ew,
                         input logic ev, input logic ep, input logic ef, input logic eo);
    if (d) begin
      chk({nm, ".word"}, w_b, ew);
      chk({nm, ".valid"}, v_b, ev);
      chk({nm, ".perr"}, pe_b, ep);
      chk({nm, ".ferr"}, fe_b, ef);
      chk({nm, ".ovr"}, ov_b, eo);
    end else begin
      chk({nm, ".word"}, {1'b0, w_a}, ew);
      chk({nm, ".valid"}, v_a, ev);
      chk({nm, ".perr"}, pe_a, ep);
      chk({nm, ".ferr"}, fe_a, ef);
      chk({nm, ".ovr"}, ov_a, eo);
    end
  endtask

  // Drive one frame: start, data LSB first, parity, stop bit(s).
  // hold_last > 0 stretches the final stop bit to that many cycles.
  task automatic tx(input bit d, input logic [8:0] data, input logic par,
                    input logic [1:0] stops, input int hold_last);
    int cpb, nd, ns, nb;
    logic [12:0] bits;
    cpb = d ? 4 : 16;
    nd  = d ? 9 : 8;
    ns  = d ? 2 : 1;
    bits = '0;
    for (int i = 0; i < nd; i++) bits[1+i] = data[i];
    bits[1+nd] = par;
    for (int s = 0; s < ns; s++) bits[2+nd+s] = stops[s];
    nb = 2 + nd + ns;
    if (d) begin start_b = cyc; rise_b = -1; end
    else   begin start_a = cyc; rise_a = -1; end
    for (int i = 0; i < nb; i++) begin
      set_rx(d, bits[i]);
      cycles((i == nb - 1 && hold_last > 0) ? hold_last : cpb);
    end
    set_rx(d, 1'b1);
  endtask

  task automatic ack_pulse(input bit d);
    if (d) ack_b = 1'b1; else ack_a = 1'b1;
    cycles(1);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    //            dut data    par stops ack lat e_word  v  pe fe ov
    tbl[0] = '{1'b0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b1, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 9'h03C, 1'b0, 2'b11, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 9'h001, 1'b0, 2'b11, 1'b1, 1'b0, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 9'h022, 1'b0, 2'b11, 1'b1, 1'b0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 9'h1AB, 1'b1, 2'b11, 1'b1, 1'b1, 9'h1AB, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 9'h0FF, 1'b0, 2'b11, 1'b1, 1'b0, 9'h0FF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 9'h100, 1'b0, 2'b01, 1'b1, 1'b0, 9'h100, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 9'h000, 1'b1, 2'b10, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0};

    cycles(3);
    @(negedge clk);
    chk_out(1'b0, "reset_a", 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out(1'b1, "reset_b", 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(1);
    res = 1'b1;
    cycles(3);

    // short low pulse in IDLE must be rejected as a false start
    rx_a = 1'b0;
    cycles(5);
    rx_a = 1'b1;
    cycles(200);
    @(negedge clk);
    chk("glitch.valid", v_a, 1'b0);
    cycles(1);

    for (int i = 0; i < 9; i++) begin
      tx(tbl[i].dut, tbl[i].data, tbl[i].par, tbl[i].stops, 0);
      cycles(2);
      @(negedge clk);
      chk_out(tbl[i].dut, $sformatf("vec%0d", i), tbl[i].e_word, tbl[i].e_valid,
              tbl[i].e_perr, tbl[i].e_ferr, tbl[i].e_ovr);
      if (tbl[i].lat) begin
        if (tbl[i].dut) chk($sformatf("vec%0d.latency", i), rise_b, start_b + 1 + 52);
        else            chk($sformatf("vec%0d.latency", i), rise_a, start_a + 1 + 170);
      end
      cycles(1);
      if (tbl[i].ack) begin
        ack_pulse(tbl[i].dut);
        @(negedge clk);
        if (tbl[i].dut) begin
          chk($sformatf("vec%0d.ack_valid", i), v_b, 1'b0);
          chk($sformatf("vec%0d.ack_ovr", i), ov_b, 1'b0);
        end else begin
          chk($sformatf("vec%0d.ack_valid", i), v_a, 1'b0);
          chk($sformatf("vec%0d.ack_ovr", i), ov_a, 1'b0);
        end
        cycles(1);
      end
    end

    // overrun, then an ack landing on the completion edge of a third frame
    tx(1'b0, 9'h011, 1'b0, 2'b11, 0);
    tx(1'b0, 9'h022, 1'b0, 2'b11, 0);
    @(negedge clk);
    chk("ovr2.ovr", ov_a, 1'b1);
    chk("ovr2.word", w_a, 8'h11);
    cycles(1);
    fork
      tx(1'b0, 9'h033, 1'b0, 2'b11, 0);
      begin
        repeat (170) @(posedge clk);
        #1 ack_a = 1'b1;
        @(posedge clk);
        #1 ack_a = 1'b0;
      end
    join
    @(negedge clk);
    chk_out(1'b0, "ackcomp", 9'h033, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles(1);
    ack_pulse(1'b0);

    // low stop bit held 40 cycles: framing error, no frame out of the break
    tx(1'b0, 9'h055, 1'b0, 2'b00, 40);
    cycles(2);
    @(negedge clk);
    chk_out(1'b0, "break", 9'h055, 1'b1, 1'b0, 1'b1, 1'b0);
    cycles(1);
    ack_pulse(1'b0);
    cycles(250);
    @(negedge clk);
    chk("break.no_second", v_a, 1'b0);
    cycles(1);

    // ENABLE dropped in the middle of data bit 4
    fork
      tx(1'b0, 9'h07E, 1'b0, 2'b11, 0);
      begin
        repeat (88) @(posedge clk);
        #1 en = 1'b0;
      end
    join
    cycles(5);
    en = 1'b1;
    cycles(200);
    @(negedge clk);
    chk("abort.valid", v_a, 1'b0);
    cycles(1);

    // asynchronous reset in the middle of a frame with a word held
    tx(1'b0, 9'h05A, 1'b0, 2'b11, 0);
    cycles(2);
    @(negedge clk);
    chk("rstmid.pre_valid", v_a, 1'b1);
    cycles(1);
    fork
      tx(1'b0, 9'h066, 1'b0, 2'b11, 0);
      begin
        repeat (60) @(posedge clk);
        #1 res = 1'b0;
        #1 chk_out(1'b0, "rstmid", 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    join
    cycles(1);
    res = 1'b1;
    cycles(200);
    @(negedge clk);
    chk_out(1'b0, "rstmid.after", 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
